// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between a fetch requester and a
// data requester with paired two-beat accesses, starvation bounding and fetch kill.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [14:0] f_addr,
    output logic        f_ready,
    input  logic        f_kill,
    output logic        f_rvalid,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_pair,
    input  logic [14:0] d_addr,
    input  logic [15:0] d_wdata0,
    input  logic [15:0] d_wdata1,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic        d_rbeat,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PAIR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [AW-1:0]   pair_addr_q, pair_addr_d;
    logic            pair_we_q, pair_we_d;
    logic [DW-1:0]   pair_wdata_q, pair_wdata_d;
    logic            f_pend_q, f_pend_d;
    logic            d_pend_q, d_pend_d;
    logic            d_beat_q, d_beat_d;
    logic            done_q, done_d;
    logic            starved;

    // State and response pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            pair_addr_q  <= '0;
            pair_we_q    <= 1'b0;
            pair_wdata_q <= '0;
            f_pend_q     <= 1'b0;
            d_pend_q     <= 1'b0;
            d_beat_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            pair_addr_q  <= pair_addr_d;
            pair_we_q    <= pair_we_d;
            pair_wdata_q <= pair_wdata_d;
            f_pend_q     <= f_pend_d;
            d_pend_q     <= d_pend_d;
            d_beat_q     <= d_beat_d;
            done_q       <= done_d;
        end
    end

    // Arbitration, memory drive and next-state
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        pair_addr_d  = pair_addr_q;
        pair_we_d    = pair_we_q;
        pair_wdata_d = pair_wdata_q;
        f_pend_d     = 1'b0;
        d_pend_d     = 1'b0;
        d_beat_d     = 1'b0;
        done_d       = 1'b0;
        d_ready      = 1'b0;
        f_ready      = 1'b0;
        mem_en       = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = d_addr;
        mem_wdata    = d_wdata0;
        starved      = f_req && (starve_q == CNT_MAX);

        if (!rst) begin
            if (!f_req) begin
                starve_d = '0;
            end
            case (state_q)
                S_IDLE: begin
                    d_ready = d_req && !starved;
                    f_ready = f_req && !d_ready;
                    if (d_ready) begin
                        mem_en    = 1'b1;
                        mem_wen   = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata0;
                        d_pend_d  = !d_we;
                        if (f_req && (starve_q != CNT_MAX)) begin
                            starve_d = starve_q + CW'(1);
                        end
                        if (d_pair) begin
                            pair_addr_d  = d_addr;
                            pair_we_d    = d_we;
                            pair_wdata_d = d_wdata1;
                            state_d      = S_PAIR;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (f_ready) begin
                        mem_en   = 1'b1;
                        mem_addr = f_addr;
                        f_pend_d = !f_kill;
                        starve_d = '0;
                    end
                end
                S_PAIR: begin
                    // Second beat is locked; address wraps naturally at AW bits
                    mem_en    = 1'b1;
                    mem_wen   = pair_we_q;
                    mem_addr  = pair_addr_q + AW'(1);
                    mem_wdata = pair_wdata_q;
                    d_pend_d  = !pair_we_q;
                    d_beat_d  = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Responses are dropped while rst is high, and a late kill still cancels fetch data
    assign f_rvalid = f_pend_q && !f_kill && !rst;
    assign f_rdata  = mem_rdata;
    assign d_rvalid = d_pend_q && !rst;
    assign d_rbeat  = d_beat_q;
    assign d_rdata  = mem_rdata;
    assign d_done   = done_q && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a synchronous memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_kill, f_ready, f_rvalid;
    logic [14:0] f_addr;
    logic [15:0] f_rdata;
    logic        d_req, d_we, d_pair, d_ready, d_rvalid, d_rbeat, d_done;
    logic [14:0] d_addr;
    logic [15:0] d_wdata0, d_wdata1, d_rdata;
    logic        mem_en, mem_wen;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem [0:32767];
    bit          loaded = 1'b0;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_kill(f_kill),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_pair(d_pair), .d_addr(d_addr),
        .d_wdata0(d_wdata0), .d_wdata1(d_wdata1), .d_ready(d_ready),
        .d_rvalid(d_rvalid), .d_rbeat(d_rbeat), .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory preloaded with 0xA000+addr, one-cycle read latency
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 16'hA000 + 16'(i);
            loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_wen) mem[mem_addr] <= mem_wdata;
            else         mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; f_kill = 0; f_addr = '0;
        d_req = 0; d_we = 0; d_pair = 0; d_addr = '0; d_wdata0 = '0; d_wdata1 = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step(); step();
        // Reset blocks both grants even with requests pending
        f_req = 1; d_req = 1; settle();
        check("rst_f_ready", 32'(f_ready), 0);
        check("rst_d_ready", 32'(d_ready), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_f_rvalid", 32'(f_rvalid), 0);
        check("rst_d_rvalid", 32'(d_rvalid), 0);
        check("rst_d_done", 32'(d_done), 0);
        step(); rst = 0; idle_inputs();
        step();

        // Fetch stream
        for (int i = 0; i < 4; i++) begin
            f_req = (i < 3); f_addr = 15'h0010 + 15'(i); settle();
            check("fetch_ready", 32'(f_ready), 32'(i < 3));
            check("fetch_mem_en", 32'(mem_en), 32'(i < 3));
            if (i < 3) check("fetch_mem_addr", 32'(mem_addr), 32'h10 + 32'(i));
            check("fetch_rvalid", 32'(f_rvalid), 32'(i > 0));
            if (i > 0) check("fetch_rdata", 32'(f_rdata), 32'hA00F + 32'(i));
            step();
        end
        idle_inputs(); step();

        // Pair load across the wrap point while fetch waits
        d_req = 1; d_pair = 1; d_addr = 15'h7FFF; f_req = 1; f_addr = 15'h0050; settle();
        check("pl_d_ready", 32'(d_ready), 1);
        check("pl_f_ready0", 32'(f_ready), 0);
        check("pl_addr0", 32'(mem_addr), 32'h7FFF);
        check("pl_wen0", 32'(mem_wen), 0);
        step(); d_req = 0; d_pair = 0; settle();
        check("pl_f_ready1", 32'(f_ready), 0);
        check("pl_d_ready1", 32'(d_ready), 0);
        check("pl_en1", 32'(mem_en), 1);
        check("pl_addr1", 32'(mem_addr), 32'h0000);
        check("pl_rvalid0", 32'(d_rvalid), 1);
        check("pl_rbeat0", 32'(d_rbeat), 0);
        check("pl_rdata0", 32'(d_rdata), 32'h1FFF);
        check("pl_done_early", 32'(d_done), 0);
        step(); settle();
        check("pl_f_ready2", 32'(f_ready), 1);
        check("pl_f_addr2", 32'(mem_addr), 32'h0050);
        check("pl_rvalid1", 32'(d_rvalid), 1);
        check("pl_rbeat1", 32'(d_rbeat), 1);
        check("pl_rdata1", 32'(d_rdata), 32'hA000);
        check("pl_done", 32'(d_done), 1);
        step(); f_req = 0; settle();
        check("pl_f_rvalid", 32'(f_rvalid), 1);
        check("pl_f_rdata", 32'(f_rdata), 32'hA050);
        check("pl_done_after", 32'(d_done), 0);
        step();

        // Pair store
        d_req = 1; d_pair = 1; d_we = 1; d_addr = 15'h0020; d_wdata0 = 16'h1234; d_wdata1 = 16'h5678; settle();
        check("ps_d_ready", 32'(d_ready), 1);
        check("ps_wen0", 32'(mem_wen), 1);
        check("ps_wdata0", 32'(mem_wdata), 32'h1234);
        step(); idle_inputs(); settle();
        check("ps_en1", 32'(mem_en), 1);
        check("ps_wen1", 32'(mem_wen), 1);
        check("ps_addr1", 32'(mem_addr), 32'h0021);
        check("ps_wdata1", 32'(mem_wdata), 32'h5678);
        check("ps_rvalid0", 32'(d_rvalid), 0);
        check("ps_done_early", 32'(d_done), 0);
        step(); settle();
        check("ps_done", 32'(d_done), 1);
        check("ps_rvalid1", 32'(d_rvalid), 0);
        check("ps_en2", 32'(mem_en), 0);
        check("ps_mem20", 32'(mem[15'h0020]), 32'h1234);
        check("ps_mem21", 32'(mem[15'h0021]), 32'h5678);
        // Single load reads back the second beat
        d_req = 1; d_addr = 15'h0021; settle();
        check("sl_d_ready", 32'(d_ready), 1);
        step(); idle_inputs(); settle();
        check("sl_rvalid", 32'(d_rvalid), 1);
        check("sl_rbeat", 32'(d_rbeat), 0);
        check("sl_rdata", 32'(d_rdata), 32'h5678);
        check("sl_done", 32'(d_done), 1);
        step();

        // Starvation: four data accepts, then one fetch, repeating
        d_req = 1; d_addr = 15'h0030; f_req = 1; f_addr = 15'h0060;
        for (int i = 0; i < 10; i++) begin
            settle();
            check("starve_d_ready", 32'(d_ready), 32'((i % 5) != 4));
            check("starve_f_ready", 32'(f_ready), 32'((i % 5) == 4));
            check("starve_addr", 32'(mem_addr), ((i % 5) == 4) ? 32'h60 : 32'h30);
            step();
        end
        idle_inputs(); step(); step();

        // Kill in the response cycle, then a normal fetch
        f_req = 1; f_addr = 15'h0040; settle();
        check("kill_f_ready", 32'(f_ready), 1);
        step(); f_req = 0; f_kill = 1; settle();
        check("kill_resp", 32'(f_rvalid), 0);
        step(); f_kill = 0; f_req = 1; f_addr = 15'h0041; settle();
        check("kill_no_late", 32'(f_rvalid), 0);
        check("kill_f_ready2", 32'(f_ready), 1);
        step(); f_req = 1; f_kill = 1; f_addr = 15'h0042; settle();
        check("kill_next_rvalid", 32'(f_rvalid), 0);
        // Kill in the accept cycle
        step(); f_req = 0; f_kill = 0; settle();
        check("kill_accept", 32'(f_rvalid), 0);
        step(); f_req = 1; f_addr = 15'h0041; settle();
        step(); f_req = 0; settle();
        check("unkilled_rvalid", 32'(f_rvalid), 1);
        check("unkilled_rdata", 32'(f_rdata), 32'hA041);
        step();

        // Reset during a pending pair
        d_req = 1; d_pair = 1; d_addr = 15'h0100; settle();
        check("rp_d_ready", 32'(d_ready), 1);
        step(); idle_inputs(); rst = 1; settle();
        check("rp_en", 32'(mem_en), 0);
        check("rp_rvalid", 32'(d_rvalid), 0);
        check("rp_done", 32'(d_done), 0);
        step(); rst = 0; settle();
        check("rp_en_after", 32'(mem_en), 0);
        check("rp_rvalid_after", 32'(d_rvalid), 0);
        check("rp_done_after", 32'(d_done), 0);
        f_req = 1; f_addr = 15'h0101; settle();
        check("rp_f_ready", 32'(f_ready), 1);
        step(); f_req = 0; settle();
        check("rp_f_rvalid", 32'(f_rvalid), 1);
        check("rp_f_rdata", 32'(f_rdata), 32'hA101);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
